trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences trap entry and trap return for the core. The block owns the STATUS, SCAUSE, INTMASK and SEPC control registers. It also owns the priority encoding of pending causes, the pipeline flush/stall handshake and the PC redirect to the trap vector or back to SEPC. It sits between the pipeline's exception strobes and the fetch-stage PC mux.

## Interface
Parameters:
- VEC_BASE, 32'h0000_1000: trap vector base; vector = VEC_BASE + {code, 2'b00}.
- PC_W, 32: PC width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (one clock domain only).
- cause_req  in  8  per-cycle exception strobes; bit0 illegal_instr, bit1 ecall, bits2-6 reserve1..5, bit7 unused (ignored).
- timer_irq  in  1  level timer interrupt (present only with TRAP_TIMER_EN).
- int_ret  in  1  one-cycle pulse, sret retired.
- ex_pc  in  PC_W  PC of the instruction raising cause_req / current commit PC.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  2  register select: 0 STATUS, 1 SCAUSE, 2 INTMASK, 3 SEPC.
- csr_wdata  in  PC_W  write data; 8-bit CSRs take [7:0].
- redirect_ack  in  1  fetch accepted redirect_pc.
- flush  out  1  kill in-flight instructions.
- stall  out  1  freeze pipeline while sequencing.
- redirect_valid  out  1  redirect_pc valid.
- redirect_pc  out  PC_W  target PC.
- status, scause, intmask  out  8  register values.
- sepc  out  PC_W  saved PC.
- int_pend  out  3  code of the trap being or last taken.

## Operation
- STATUS bit1 = IE, bit0 = EXL. Other STATUS bits are plain storage.
- SCAUSE accumulates cause_req bits in IDLE: scause <= scause | cause_req[6:0].
- Pending set = scause & intmask.
- trap_cond = (|pending | timer_irq) & IE & ~EXL.
- Priority: timer first (code 7). Otherwise the lowest set pending bit gives code = bit index: illegal 0, ecall 1, reserve1..5 → 2..6.
- FSM states and transitions:
  - IDLE → FLUSH when trap_cond. Latch code and ex_pc.
  - IDLE → RETURN when int_ret & EXL. Otherwise int_ret is ignored.
  - FLUSH: flush=1 for 1 cycle, then → SAVE.
  - SAVE: sepc <= latched pc, EXL <= 1, int_pend <= code, then → VECTOR.
  - VECTOR: redirect_valid=1, redirect_pc = VEC_BASE + code*4. Held until redirect_ack, then → IDLE.
  - RETURN: redirect_valid=1, redirect_pc = sepc. Until redirect_ack, then EXL <= 0, clear scause bit int_pend (code 7: none), → IDLE.
- stall = (state != IDLE).
- CSR writes apply only in IDLE and are ignored elsewhere.
- A CSR write in the same cycle as trap detection is applied, but detection uses the pre-write register values.
- Same-cycle CSR write and cause_req accumulation to SCAUSE: the write wins.
- trap_cond and a return are exclusive, because EXL gates both.
- A redirect_ack outside VECTOR/RETURN is ignored.

## Timing
- Reset (rst low, async) values: state IDLE; all outputs 0; status 8'h00; scause 8'h00; intmask 8'h00; sepc 0; int_pend 3'd0.
- Trap latency: detection cycle N; flush at N+1; SEPC/EXL update visible at N+3; redirect_valid from N+3 until ack.
- Minimum trap entry is 4 cycles with ack in the first VECTOR cycle.
- Return: redirect_valid from N+1; EXL clears at the edge after ack.
- redirect_pc is stable while redirect_valid is high.
- Reset asserted mid-sequence aborts to IDLE with reset values; no partial SEPC write survives.

## Configuration
- TRAP_TIMER_EN defined: timer_irq port exists and participates as the code-7 highest-priority source.
- TRAP_TIMER_EN undefined: port absent, treated as 0, code 7 is never produced.

## Structure
- Shared package/include (ctrl_encode_def.v) holds:
  - scause bit positions;
  - int_* 3-bit codes;
  - CSR address constants;
  - STATUS IE/EXL bit indices;
  - FSM state encodings.
- One sub-module: trap_prio_enc. It is combinational and maps {timer, pending[6:0]} to {any, code[2:0]}.

## Test plan
- Reset, then write STATUS=8'h02, INTMASK=8'h01. Pulse cause_req=8'h01 with ex_pc=32'h200.
  - flush one cycle later.
  - Then sepc=32'h200, status=8'h03, int_pend=0, redirect_pc=32'h1000 until ack.
- With trap pending, hold redirect_ack low 5 cycles → redirect_valid and redirect_pc stable, stall high throughout.
- cause_req=8'h03 with INTMASK=8'h03 → code 0 taken. After return, scause=8'h02 and ecall traps next with redirect_pc=32'h1004.
- EXL=1, new cause_req → no trap. int_ret → redirect_pc=sepc, EXL clears after ack, pending ecall then traps.
- TRAP_TIMER_EN: timer_irq with ecall pending → int_pend=7, redirect_pc=32'h101C.
- Assert rst in SAVE → all outputs reset values immediately; no redirect after release.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared encodings for the trap sequencer: cause bits, trap codes, CSR map,
// STATUS bit indices and FSM states.
package trap_sequencer_pkg;

  localparam int SC_ILLEGAL  = 0;
  localparam int SC_ECALL    = 1;
  localparam int SC_RESERVE1 = 2;

  localparam logic [2:0] INT_ILLEGAL = 3'd0;
  localparam logic [2:0] INT_ECALL   = 3'd1;
  localparam logic [2:0] INT_TIMER   = 3'd7;

  localparam logic [1:0] CSR_STATUS  = 2'd0;
  localparam logic [1:0] CSR_SCAUSE  = 2'd1;
  localparam logic [1:0] CSR_INTMASK = 2'd2;
  localparam logic [1:0] CSR_SEPC    = 2'd3;

  localparam int STATUS_EXL = 0;
  localparam int STATUS_IE  = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_RETURN = 3'd4
  } state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder: timer wins as code 7, otherwise the
// lowest set pending bit gives the code.
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic       timer,
  input  logic [6:0] pending,
  output logic       any,
  output logic [2:0] code
);

  always_comb begin
    any  = timer | (|pending);
    code = INT_ILLEGAL;
    if (timer) begin
      code = INT_TIMER;
    end else begin
      // Scan downward so the lowest set bit is the last one assigned.
      for (int i = 6; i >= 0; i--) begin
        if (pending[i]) code = 3'(i);
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer owning STATUS, SCAUSE, INTMASK and SEPC.
// Define TRAP_TIMER_EN to add the timer_irq port as the code-7 source.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int            PC_W     = 32,
  parameter logic [PC_W-1:0] VEC_BASE = 'h0000_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      cause_req,
`ifdef TRAP_TIMER_EN
  input  logic            timer_irq,
`endif
  input  logic            int_ret,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            csr_we,
  input  logic [1:0]      csr_addr,
  input  logic [PC_W-1:0] csr_wdata,
  input  logic            redirect_ack,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [7:0]      status,
  output logic [7:0]      scause,
  output logic [7:0]      intmask,
  output logic [PC_W-1:0] sepc,
  output logic [2:0]      int_pend
);

  state_t          state;
  logic            timer;
  logic            any;
  logic [2:0]      code;
  logic            trap_cond;
  logic [2:0]      trap_code;
  logic [PC_W-1:0] trap_pc;

`ifdef TRAP_TIMER_EN
  assign timer = timer_irq;
`else
  assign timer = 1'b0;
`endif

  trap_prio_enc u_prio (
    .timer   (timer),
    .pending (scause[6:0] & intmask[6:0]),
    .any     (any),
    .code    (code)
  );

  assign trap_cond = any & status[STATUS_IE] & ~status[STATUS_EXL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      status         <= 8'h00;
      scause         <= 8'h00;
      intmask        <= 8'h00;
      sepc           <= '0;
      int_pend       <= 3'd0;
      trap_code      <= 3'd0;
      trap_pc        <= '0;
    end else begin
      flush <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Detection below reads pre-write values; a CSR write to SCAUSE
          // overrides the same-cycle accumulation.
          scause <= scause | (cause_req & 8'h7F);
          if (csr_we) begin
            unique case (csr_addr)
              CSR_STATUS:  status  <= csr_wdata[7:0];
              CSR_SCAUSE:  scause  <= csr_wdata[7:0];
              CSR_INTMASK: intmask <= csr_wdata[7:0];
              CSR_SEPC:    sepc    <= csr_wdata;
            endcase
          end
          if (trap_cond) begin
            state     <= S_FLUSH;
            flush     <= 1'b1;
            stall     <= 1'b1;
            trap_code <= code;
            trap_pc   <= ex_pc;
          end else if (int_ret && status[STATUS_EXL]) begin
            state          <= S_RETURN;
            stall          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= sepc;
          end
        end
        S_FLUSH: state <= S_SAVE;
        S_SAVE: begin
          sepc               <= trap_pc;
          status[STATUS_EXL] <= 1'b1;
          int_pend           <= trap_code;
          redirect_valid     <= 1'b1;
          redirect_pc        <= VEC_BASE + PC_W'({trap_code, 2'b00});
          state              <= S_VECTOR;
        end
        S_VECTOR: begin
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_RETURN: begin
          if (redirect_ack) begin
            status[STATUS_EXL] <= 1'b0;
            if (int_pend != INT_TIMER) scause <= scause & ~(8'd1 << int_pend);
            redirect_valid     <= 1'b0;
            stall              <= 1'b0;
            state              <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a cycle-timing reference model.
// Timer cases are built only when TRAP_TIMER_EN is defined.
module tb_trap_sequencer;

  localparam logic [31:0] VEC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  cause_req = 8'h00;
  logic        timer_irq = 1'b0;
  logic        int_ret = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        csr_we = 1'b0;
  logic [1:0]  csr_addr = 2'd0;
  logic [31:0] csr_wdata = 32'h0;
  logic        redirect_ack = 1'b0;
  logic        flush, stall, redirect_valid;
  logic [31:0] redirect_pc, sepc;
  logic [7:0]  status, scause, intmask;
  logic [2:0]  int_pend;

  int total = 0;
  int bad = 0;

  trap_sequencer #(.PC_W(32), .VEC_BASE(VEC)) dut (
    .clk            (clk),
    .rst            (rst),
    .cause_req      (cause_req),
`ifdef TRAP_TIMER_EN
    .timer_irq      (timer_irq),
`endif
    .int_ret        (int_ret),
    .ex_pc          (ex_pc),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .redirect_ack   (redirect_ack),
    .flush          (flush),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .status         (status),
    .scause         (scause),
    .intmask        (intmask),
    .sepc           (sepc),
    .int_pend       (int_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: trap_k counts cycles since detection (1 = flush cycle,
  // >=3 = redirect offered); ret_on marks a return awaiting ack.
  logic [7:0]  m_status = 8'h00, m_scause = 8'h00, m_intmask = 8'h00;
  logic [31:0] m_sepc = 32'h0, m_pc = 32'h0, m_rpc = 32'h0;
  logic [2:0]  m_code = 3'd0, m_int_pend = 3'd0;
  int          trap_k = 0;
  bit          ret_on = 1'b0;
  logic [6:0]  m_p;
  bit          m_fire;
  int          m_c;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_status = 8'h00; m_scause = 8'h00; m_intmask = 8'h00;
      m_sepc = 32'h0; m_pc = 32'h0; m_rpc = 32'h0;
      m_code = 3'd0; m_int_pend = 3'd0; trap_k = 0; ret_on = 1'b0;
    end else if (trap_k != 0) begin
      if (trap_k >= 3) begin
        if (redirect_ack) trap_k = 0;
      end else begin
        if (trap_k == 2) begin
          m_sepc = m_pc;
          m_status[0] = 1'b1;
          m_int_pend = m_code;
        end
        trap_k++;
      end
    end else if (ret_on) begin
      if (redirect_ack) begin
        ret_on = 1'b0;
        m_status[0] = 1'b0;
        if (m_int_pend != 3'd7) m_scause[m_int_pend] = 1'b0;
      end
    end else begin
      m_p = m_scause[6:0] & m_intmask[6:0];
      m_fire = (m_p != 7'd0 || timer_irq) && m_status[1] && !m_status[0];
      m_c = 7;
      if (!timer_irq) begin
        m_c = 0;
        while (m_c < 7 && !m_p[m_c]) m_c++;
      end
      if (m_fire) begin
        trap_k = 1; m_code = 3'(m_c); m_pc = ex_pc;
      end else if (int_ret && m_status[0]) begin
        ret_on = 1'b1; m_rpc = m_sepc;
      end
      m_scause = m_scause | {1'b0, cause_req[6:0]};
      if (csr_we) begin
        case (csr_addr)
          2'd0: m_status = csr_wdata[7:0];
          2'd1: m_scause = csr_wdata[7:0];
          2'd2: m_intmask = csr_wdata[7:0];
          default: m_sepc = csr_wdata;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("flush", 32'(flush), 32'(trap_k == 1));
    chk("stall", 32'(stall), 32'(trap_k != 0 || ret_on));
    chk("redirect_valid", 32'(redirect_valid), 32'((trap_k >= 3) || ret_on));
    if ((trap_k >= 3) || ret_on)
      chk("redirect_pc", redirect_pc, ret_on ? m_rpc : VEC + 32'(m_code) * 32'd4);
    chk("status", 32'(status), 32'(m_status));
    chk("scause", 32'(scause), 32'(m_scause));
    chk("intmask", 32'(intmask), 32'(m_intmask));
    chk("sepc", sepc, m_sepc);
    chk("int_pend", 32'(int_pend), 32'(m_int_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [1:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_sepc", sepc, 32'h0);
    chk("rst_rv", 32'(redirect_valid), 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    rst = 1'b1;
    tick();

    // First trap: illegal instruction at 0x200.
    csr(2'd0, 32'h02); tick();
    csr(2'd2, 32'h01); tick();
    csr_we = 1'b0;
    chk("status_wr", 32'(status), 32'h02);
    cause_req = 8'h01; ex_pc = 32'h200; tick();
    cause_req = 8'h00;
    chk("scause_acc", 32'(scause), 32'h01);
    tick();
    chk("flush_n1", 32'(flush), 32'h1);
    tick();
    chk("rv_n2", 32'(redirect_valid), 32'h0);
    tick();
    chk("sepc_n3", sepc, 32'h200);
    chk("status_n3", 32'(status), 32'h03);
    chk("rpc_n3", redirect_pc, 32'h1000);

    // Hold ack low; a CSR write here must be dropped.
    csr(2'd3, 32'hDEAD); tick();
    csr_we = 1'b0;
    repeat (4) tick();
    chk("rpc_hold", redirect_pc, 32'h1000);
    chk("stall_hold", 32'(stall), 32'h1);
    redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;
    chk("rv_after_ack", 32'(redirect_valid), 32'h0);
    chk("sepc_kept", sepc, 32'h200);

    // EXL set: stray ack and new ecall must not start anything.
    redirect_ack = 1'b1; csr(2'd2, 32'h03); cause_req = 8'h02; tick();
    redirect_ack = 1'b0; csr_we = 1'b0; cause_req = 8'h00;
    tick(); tick();
    chk("no_trap_exl", 32'(stall), 32'h0);

    // Return, then the pending ecall traps straight away.
    ex_pc = 32'h300; int_ret = 1'b1; tick();
    int_ret = 1'b0;
    chk("ret_rpc", redirect_pc, 32'h200);
    tick();
    redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;
    chk("ret_status", 32'(status), 32'h02);
    chk("ret_scause", 32'(scause), 32'h02);
    tick(); tick(); tick();
    chk("ecall_rpc", redirect_pc, 32'h1004);
    chk("ecall_code", 32'(int_pend), 32'h1);
    chk("ecall_sepc", sepc, 32'h300);
    redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;

    // Return with ack in the first cycle, then both causes at once.
    int_ret = 1'b1; tick();
    int_ret = 1'b0; redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;
    chk("scause_clr", 32'(scause), 32'h00);
    cause_req = 8'h03; ex_pc = 32'h400; tick();
    cause_req = 8'h00;
    tick(); tick(); tick();
    chk("both_code", 32'(int_pend), 32'h0);
    chk("both_rpc", redirect_pc, 32'h1000);
    redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;

    // Return re-arms ecall; abort it with reset while in SAVE.
    int_ret = 1'b1; tick();
    int_ret = 1'b0; redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_sepc", sepc, 32'h0);
    chk("abort_scause", 32'(scause), 32'h0);
    tick(); tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("abort_no_redirect", 32'(redirect_valid), 32'h0);

`ifdef TRAP_TIMER_EN
    ex_pc = 32'h500; csr(2'd2, 32'h02); tick();
    csr(2'd0, 32'h02); cause_req = 8'h02; timer_irq = 1'b1; tick();
    csr_we = 1'b0; cause_req = 8'h00;
    tick();
    timer_irq = 1'b0;
    tick(); tick();
    chk("timer_code", 32'(int_pend), 32'h7);
    chk("timer_rpc", redirect_pc, 32'h101C);
    redirect_ack = 1'b1; tick();
    redirect_ack = 1'b0;
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
